tree_accum_seq: RTL



---
 rtl/tree_accum_pkg.sv | 20 ++
 rtl/tree.sv | 40 ++++
 rtl/tree_accum_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/tree_accum_pkg.sv
// Shared types and constants for the tree accumulator sequencer.
//   state_e      : sequencer states (ACCUM, RESOLVE, HOLD)
//   TREE_IN      : compressor input count for the default lane count
//   tree_inputs  : compressor input count for any lane count (lanes + acc0 + acc1)
package tree_accum_pkg;

   localparam int DEF_NUM_LANES = 6;
   localparam int TREE_IN       = DEF_NUM_LANES + 2;

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      RESOLVE = 2'd1,
      HOLD    = 2'd2
   } state_e;

   function automatic int tree_inputs(input int num_lanes);
      return num_lanes + 2;
   endfunction

endpackage

// File: rtl/tree.sv
// Carry-save compressor: reduces num_inputs operands to two words whose
// sum equals the sum of all inputs, mod 2^input_width.
//   in_vec : packed operands [num_inputs-1:0][input_width-1:0]
//   out0   : sum word
//   out1   : carry word (already shifted into position)
// Built as a chain of 3:2 full-adder rows; each row folds one more operand
// into the running (sum, carry) pair. Requires num_inputs >= 2.
module tree
   import tree_accum_pkg::*;
#(
   parameter int num_inputs  = TREE_IN,
   parameter int input_width = 64
) (
   input  logic [num_inputs-1:0][input_width-1:0] in_vec,
   output logic [input_width-1:0]                 out0,
   output logic [input_width-1:0]                 out1
);

   logic [input_width-1:0] s_chain [1:num_inputs-1];
   logic [input_width-1:0] c_chain [1:num_inputs-1];

   // The first two operands are already a valid (sum, carry) pair.
   assign s_chain[1] = in_vec[0];
   assign c_chain[1] = in_vec[1];

   generate
      for (genvar gi = 2; gi < num_inputs; gi++) begin : g_csa_row
         assign s_chain[gi] = s_chain[gi-1] ^ c_chain[gi-1] ^ in_vec[gi];
         // Majority is the carry; shifting left drops the top carry, which
         // is exactly the mod 2^input_width behaviour wanted.
         assign c_chain[gi] = ((s_chain[gi-1] & c_chain[gi-1]) |
                               (s_chain[gi-1] & in_vec[gi])    |
                               (c_chain[gi-1] & in_vec[gi])) << 1;
      end
   endgenerate

   assign out0 = s_chain[num_inputs-1];
   assign out1 = c_chain[num_inputs-1];

endmodule

// File: rtl/tree_accum_seq.sv
// Multi-beat packet reducer. Each accepted beat is compressed together with
// the carry-save feedback pair (acc0, acc1); after the last beat a single
// carry-propagate add resolves the pair and the result is held until the
// consumer accepts it.
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid/in_ready    : beat handshake; in_data lanes, in_last ends packet
//   out_valid/out_ready  : result handshake
//   out_sum              : packet sum mod 2^WIDTH
//   out_count            : beats in packet, saturating at 2^CNT_W-1
module tree_accum_seq
   import tree_accum_pkg::*;
#(
   parameter int NUM_LANES = DEF_NUM_LANES,
   parameter int WIDTH     = 64,
   parameter int CNT_W     = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [NUM_LANES-1:0][WIDTH-1:0]  in_data,
   input  logic                             in_last,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [WIDTH-1:0]                 out_sum,
   output logic [CNT_W-1:0]                 out_count
);

   localparam int N_IN = tree_inputs(NUM_LANES);

   state_e                      state_q, state_d;
   logic [WIDTH-1:0]            acc0_q, acc0_d;
   logic [WIDTH-1:0]            acc1_q, acc1_d;
   logic [WIDTH-1:0]            sum_q, sum_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [CNT_W-1:0]            count_q, count_d;
   logic [N_IN-1:0][WIDTH-1:0]  tree_in;
   logic [WIDTH-1:0]            tree_out0, tree_out1;
   logic                        beat_fire;

   // Lanes occupy the low slots, feedback pair the top two.
   assign tree_in = {acc1_q, acc0_q, in_data};

   tree #(
      .num_inputs  (N_IN),
      .input_width (WIDTH)
   ) u_tree (
      .in_vec (tree_in),
      .out0   (tree_out0),
      .out1   (tree_out1)
   );

   // Handshake flags are pure state decodes, so neither depends on the
   // opposite side's valid/ready in the same cycle.
   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign out_sum   = sum_q;
   assign out_count = count_q;
   assign beat_fire = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      acc0_d  = acc0_q;
      acc1_d  = acc1_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      count_d = count_q;
      case (state_q)
         ACCUM: begin
            if (beat_fire) begin
               acc0_d = tree_out0;
               acc1_d = tree_out1;
               cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
               if (in_last) begin
                  state_d = RESOLVE;
               end
            end
         end
         RESOLVE: begin
            sum_d   = acc0_q + acc1_q;
            count_d = cnt_q;
            // Clear the feedback pair here so the next packet starts clean
            // while the result sits in HOLD.
            acc0_d  = '0;
            acc1_d  = '0;
            cnt_d   = '0;
            state_d = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               state_d = ACCUM;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ACCUM;
         acc0_q  <= '0;
         acc1_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         acc0_q  <= acc0_d;
         acc1_q  <= acc1_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         count_q <= count_d;
      end
   end

endmodule
